// File: rtl/bus_blockram_param.sv
// Block RAM slave for the 32-bit wired-OR system bus: own address window, byte-lane
// writes, 1- or 2-cycle tagged read pipeline, optional zero-fill after reset.
module bus_blockram_param #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_4000,
  parameter int unsigned SIZE_BYTES     = 16384,
  parameter bit          OUT_REG        = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_be,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        init_done
);
  localparam int unsigned DEPTH    = SIZE_BYTES / 4;
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK = ~(32'(SIZE_BYTES) - 32'd1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } rd_stage_t;

  logic [31:0]   mem [DEPTH];
  state_e        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          init_done_q;
  rd_stage_t     s1_q;
  rd_stage_t     fin;

  logic [AW-1:0] idx;
  logic          sel, run, clr_we, wr_acc, rd_req, rd_hit;

  assign idx    = bus_addr[AW+1:2];
  assign sel    = (bus_addr & WIN_MASK) == BASE_ADDR;
  assign run    = (state_q == ST_RUN) && !rst;
  assign clr_we = (state_q == ST_INIT) && !rst;
  assign wr_acc = run && sel && bus_wr;
  assign rd_req = run && sel && bus_rd && !bus_wr;
  // A read only completes against a tag captured for the very word now addressed.
  assign rd_hit = rd_req && fin.vld && (fin.idx == idx);

  assign bus_ready = wr_acc || rd_hit;
  assign bus_rdata = rd_hit ? fin.data : '0;
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_be[b]) mem[idx][8*b +: 8] <= bus_wdata[8*b +: 8];
      end
    end
  end

  // Read-first: the array is sampled every cycle, before this edge's write lands.
  always_ff @(posedge clk) begin
    s1_q.data <= mem[idx];
    s1_q.idx  <= idx;
    if (rst) s1_q.vld <= 1'b0;
    else     s1_q.vld <= rd_req;
  end

  if (OUT_REG) begin : g_out_reg
    rd_stage_t s2_q;
    always_ff @(posedge clk) begin
      s2_q.data <= s1_q.data;
      s2_q.idx  <= s1_q.idx;
      if (rst || wr_acc) s2_q.vld <= 1'b0;
      else               s2_q.vld <= s1_q.vld;
    end
    assign fin = s2_q;
  end else begin : g_no_out_reg
    assign fin = s1_q;
  end

endmodule
